// File: rtl/on_chip_fsm_pkg.sv
// Shared constants for the on-chip FSM calibration-done peripheral.
package on_chip_fsm_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_COUNT   = 2'd3;

endpackage

// File: rtl/on_chip_fsm_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for the calibration-done level.
module on_chip_fsm_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync_out,
    output logic rise_c
);

    logic       sync_1;
    logic       sync_2;
    logic       prev;
    logic [2:0] valid;

    // valid[2] marks prev as a genuine sample, so a level already high at reset release is not an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev   <= 1'b0;
            valid  <= 3'b000;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            prev   <= sync_2;
            valid  <= {valid[1:0], 1'b1};
        end
    end

    assign sync_out = sync_2;
    assign rise_c   = sync_2 & ~prev & valid[2];

endmodule

// File: rtl/on_chip_fsm_calibrate_done.sv
// Avalon-MM slave exposing calibration-done level, edge capture, edge count and interrupt.
module on_chip_fsm_calibrate_done
    import on_chip_fsm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    input  logic              in_port,
    output logic [DATA_W-1:0] readdata,
    output logic              irq
);

    logic             sync_in;
    logic             rise;
    logic             irq_mask;
    logic             edge_cap;
    logic [CNT_W-1:0] count;
    logic [DATA_W-1:0] rd_val;
    logic             wr;
    logic             rd;
    logic             unused_wdata;

    on_chip_fsm_sync_edge u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .din      (in_port),
        .sync_out (sync_in),
        .rise_c   (rise)
    );

    assign wr           = chipselect & ~write_n;
    assign rd           = chipselect & write_n;
    assign unused_wdata = ^writedata[DATA_W-1:1];

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA:    rd_val = DATA_W'(sync_in);
            ADDR_IRQMASK: rd_val = DATA_W'(irq_mask);
            ADDR_EDGECAP: rd_val = DATA_W'(edge_cap);
            ADDR_COUNT:   rd_val = DATA_W'(count);
            default:      rd_val = '0;
        endcase
    end

    // Edge set wins over a simultaneous clear, both for EDGECAP and COUNT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= 1'b0;
            edge_cap <= 1'b0;
            count    <= '0;
            readdata <= '0;
        end else begin
            if (wr && address == ADDR_IRQMASK) begin
                irq_mask <= writedata[0];
            end
            if (rise) begin
                edge_cap <= 1'b1;
            end else if (wr && address == ADDR_EDGECAP && writedata[0]) begin
                edge_cap <= 1'b0;
            end
            if (wr && address == ADDR_COUNT) begin
                count <= rise ? CNT_W'(1) : '0;
            end else if (rise && count != '1) begin
                count <= count + CNT_W'(1);
            end
            if (rd) begin
                readdata <= rd_val;
            end
        end
    end

    assign irq = edge_cap & irq_mask;

endmodule

// File: doc/on_chip_fsm_calibrate_done.md
ON_CHIP_FSM_CALIBRATE_DONE -- requirements
Module: on_chip_fsm_calibrate_done

Interface
REQ-001 Parameter CNT_W, default 16, width of the rising-edge event counter (range 1..32).
REQ-002 clk  input  1  single system clock; all state on posedge clk.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 chipselect  input  1  slave select; qualifies reads and writes.
REQ-006 write_n  input  1  active-low write strobe.
REQ-007 writedata  input  32  write data.
REQ-008 in_port  input  1  asynchronous calibration-done level from the on-chip FSM.
REQ-009 readdata  output  32  registered read data.
REQ-010 irq  output  1  level interrupt to the processor.

Function
REQ-011 in_port SHALL pass through a 2-flop synchronizer; sync_in is the second flop output.
REQ-012 A rising edge SHALL be detected when sync_in=1 and the previous-cycle sync_in=0 (third flop); edge pulse lasts exactly one cycle.
REQ-013 Register map: addr 0 DATA (RO, bit0=sync_in); addr 1 IRQMASK (RW, bit0); addr 2 EDGECAP (bit0, W1C); addr 3 COUNT (RO value, any write clears).
REQ-014 A write SHALL occur when chipselect=1 and write_n=0; writes to addr 0 SHALL be ignored.
REQ-015 IRQMASK bit0 SHALL load writedata[0] on a write to addr 1.
REQ-016 EDGECAP SHALL set on an edge pulse and clear on a write to addr 2 with writedata[0]=1; writedata[0]=0 has no effect.
REQ-017 Simultaneous edge pulse and EDGECAP clear SHALL leave EDGECAP=1 (set wins).
REQ-018 COUNT SHALL increment by 1 per edge pulse and saturate at 2^CNT_W-1 (no wrap).
REQ-019 A write to addr 3 SHALL clear COUNT to 0; simultaneous edge pulse and clear SHALL yield COUNT=1.
REQ-020 Read: when chipselect=1 and write_n=1, readdata SHALL register the addressed value, zero-extended to 32 bits, one cycle later (read latency 1).
REQ-021 When not reading, readdata SHALL hold its previous value.
REQ-022 irq SHALL equal EDGECAP & IRQMASK, combinational from registers (no extra cycle).
REQ-023 Edge-to-EDGECAP latency from an in_port transition (setup-satisfied) SHALL be 3 clk edges; DATA reflects in_port after 2.

Reset
REQ-024 On reset_n=0: synchronizer flops, IRQMASK, EDGECAP, COUNT, readdata SHALL be 0 immediately; irq SHALL be 0.
REQ-025 in_port already high at reset release SHALL NOT produce an edge (previous-sample flop resets to 0 only after sync flops are 0; first edge requires 0->1 after release as seen on sync_in).
REQ-026 Reset asserted mid-operation SHALL discard any in-flight edge and pending read.

Structure
REQ-027 Register address constants (DATA=0, IRQMASK=1, EDGECAP=2, COUNT=3) SHALL live in the shared on_chip_fsm package.
REQ-028 The synchronizer plus edge detector SHALL be one sub-module, on_chip_fsm_sync_edge; all else is flat.

Verification
REQ-029 Reset, then read addr 0..3 -> readdata 0 each, irq=0.
REQ-030 Write IRQMASK=1; raise in_port -> EDGECAP=1 and irq=1 on the 3rd clk edge; read addr 3 -> 1; write addr 2 data 1 -> irq=0 next cycle.
REQ-031 IRQMASK=0; toggle in_port 0->1 five times -> irq stays 0, EDGECAP=1, COUNT=5.
REQ-032 CNT_W=4: 20 rising edges -> COUNT=15; write addr 3 coincident with edge pulse -> COUNT=1.
REQ-033 EDGECAP clear (writedata=1) on same cycle as edge pulse -> EDGECAP remains 1; write addr 2 data 0 -> unchanged.
REQ-034 Hold in_port=1 across reset deassertion, assert reset_n=0 mid-count -> no edge counted, all registers 0, subsequent 0->1 counts once.
